// File: rtl/shift_right_seq_pkg.sv
// Shared encodings and defaults for the iterative right shifter / field extractor.
package shift_right_seq_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_STEP_MAX = 3;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MASK  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational right-shift cell: shifts by 0..3 and inserts fill bits at the top,
// with fill[step-1] landing in the MSB so rotate can feed back the low bits in order.
module shift_right_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [1:0]       i_step,
    input  logic [2:0]       i_fill,
    output logic [WIDTH-1:0] o_word
);

    always_comb begin
        o_word = i_word;
        case (i_step)
            2'd0: o_word = i_word;
            2'd1: o_word = {i_fill[0],   i_word[WIDTH-1:1]};
            2'd2: o_word = {i_fill[1:0], i_word[WIDTH-1:2]};
            2'd3: o_word = {i_fill[2:0], i_word[WIDTH-1:3]};
            default: o_word = i_word;
        endcase
    end

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter / field extractor: up to STEP_MAX bits per clock, then a
// single masking cycle, result returned over a valid/ready handshake.
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int STEP_MAX = DEF_STEP_MAX,
    localparam int AW       = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [AW-1:0]    AMOUNT,
    input  logic [1:0]       MODE,
    input  logic [AW-1:0]    MASK_LEN,
    output logic             BUSY,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [AW-1:0]    r_remain;
    logic [1:0]       r_mode;
    logic [AW-1:0]    r_mask_len;
    logic             r_sign;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    logic [1:0]       w_step;
    logic [2:0]       w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_mask;

    assign w_step = (r_remain >= AW'(STEP_MAX)) ? 2'(STEP_MAX) : r_remain[1:0];

    always_comb begin
        w_fill = 3'b000;
        case (r_mode)
            MODE_ARITH:  w_fill = {3{r_sign}};
            MODE_ROTATE: w_fill = r_shreg[2:0];
            default:     w_fill = 3'b000;
        endcase
    end

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .i_word (r_shreg),
        .i_step (w_step),
        .i_fill (w_fill),
        .o_word (w_shifted)
    );

    // Keep bit gi when gi <= MASK_LEN, so MASK_LEN = WIDTH-1 keeps everything.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign w_mask[gi] = (AW'(gi) <= r_mask_len);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_remain   <= '0;
            r_mode     <= MODE_LOGICAL;
            r_mask_len <= '0;
            r_sign     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_shreg    <= DATA_IN;
                        r_remain   <= AMOUNT;
                        r_mode     <= MODE;
                        r_mask_len <= MASK_LEN;
                        r_sign     <= DATA_IN[WIDTH-1];
                        r_busy     <= 1'b1;
                        r_state    <= (AMOUNT != '0) ? S_SHIFT : S_MASK;
                    end
                end
                S_SHIFT: begin
                    r_shreg  <= w_shifted;
                    r_remain <= r_remain - AW'(w_step);
                    if (r_remain == AW'(w_step)) begin
                        r_state <= S_MASK;
                    end
                end
                S_MASK: begin
                    r_result <= r_shreg & w_mask;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (RESULT_READY) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY         = r_busy;
    assign RESULT       = r_result;
    assign RESULT_VALID = r_valid;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: directed cases plus randomized operations checked
// against an arithmetic reference model of shift/rotate/mask and latency.
module tb_shift_right_seq;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [31:0] DATA_IN;
    logic [4:0]  AMOUNT;
    logic [1:0]  MODE;
    logic [4:0]  MASK_LEN;
    logic        BUSY;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        RESULT_READY;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    shift_right_seq dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .START        (START),
        .DATA_IN      (DATA_IN),
        .AMOUNT       (AMOUNT),
        .MODE         (MODE),
        .MASK_LEN     (MASK_LEN),
        .BUSY         (BUSY),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [31:0] d, input int amt,
                                              input logic [1:0] md, input int len);
        logic [31:0] r;
        logic [63:0] dd;
        logic [63:0] m;
        dd = {d, d} >> amt;
        case (md)
            2'b01:   r = $signed(d) >>> amt;
            2'b10:   r = dd[31:0];
            default: r = d >> amt;
        endcase
        m = (64'd1 << (len + 1)) - 64'd1;
        return r & m[31:0];
    endfunction

    // Entered #1 after a rising edge with the DUT idle; leaves it idle the same way.
    task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] md,
                          input logic [4:0] ln, input logic [31:0] exp, input int hold,
                          input bit scramble, input bit start_in_done, input string tag);
        int          cyc;
        bit          seen;
        bit          busy_ok;
        logic [31:0] res;
        DATA_IN  = d;
        AMOUNT   = a;
        MODE     = md;
        MASK_LEN = ln;
        START    = 1'b1;
        @(posedge CLK); #1;
        START   = 1'b0;
        cyc     = 0;
        seen    = 0;
        busy_ok = 1;
        while (!seen && cyc < 40) begin
            if (scramble) begin
                DATA_IN  = $urandom;
                AMOUNT   = 5'($urandom);
                MODE     = 2'($urandom);
                MASK_LEN = 5'($urandom);
            end
            if (!BUSY) busy_ok = 0;
            @(posedge CLK); #1;
            cyc++;
            if (RESULT_VALID) seen = 1;
        end
        check({tag, " valid"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'((int'(a) + 2) / 3 + 1));
        check({tag, " busy"}, 32'(busy_ok & BUSY), 32'd1);
        check({tag, " result"}, RESULT, exp);
        res = RESULT;
        for (int i = 0; i < hold; i++) begin
            START   = start_in_done;
            DATA_IN = $urandom;
            AMOUNT  = 5'($urandom);
            @(posedge CLK); #1;
            check({tag, " hold valid"}, 32'(RESULT_VALID), 32'd1);
            check({tag, " hold result"}, RESULT, res);
        end
        RESULT_READY = 1'b1;
        START        = start_in_done;
        @(posedge CLK); #1;
        RESULT_READY = 1'b0;
        START        = 1'b0;
        check({tag, " drain valid"}, 32'(RESULT_VALID), 32'd0);
        check({tag, " drain busy"}, 32'(BUSY), 32'd0);
        check({tag, " keep result"}, RESULT, res);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  a;
        logic [1:0]  md;
        logic [4:0]  ln;
        bit          never_valid;

        RESET_N      = 1'b0;
        START        = 1'b0;
        DATA_IN      = '0;
        AMOUNT       = '0;
        MODE         = '0;
        MASK_LEN     = '0;
        RESULT_READY = 1'b0;
        #1;
        check("reset busy", 32'(BUSY), 32'd0);
        check("reset valid", 32'(RESULT_VALID), 32'd0);
        check("reset result", RESULT, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("idle busy", 32'(BUSY), 32'd0);

        run_op(32'h12345678, 5'd8,  2'b00, 5'd7,  32'h00000056, 0, 0, 0, "logical");
        run_op(32'h80000000, 5'd31, 2'b01, 5'd31, 32'hFFFFFFFF, 0, 0, 0, "arith31");
        run_op(32'h80000000, 5'd31, 2'b00, 5'd31, 32'h00000001, 0, 0, 0, "logic31");
        run_op(32'h0000000F, 5'd4,  2'b10, 5'd31, 32'hF0000000, 0, 0, 0, "rotate");
        run_op(32'h0000000F, 5'd0,  2'b10, 5'd3,  32'h0000000F, 0, 0, 0, "rotate0");
        run_op(32'h87654321, 5'd12, 2'b11, 5'd31, 32'h00087654, 0, 0, 0, "reserved");
        run_op(32'hDEADBEEF, 5'd5,  2'b01, 5'd15,
               ref_model(32'hDEADBEEF, 5, 2'b01, 15), 5, 0, 1, "backpressure");
        run_op(32'h0000ABCD, 5'd3,  2'b00, 5'd15, 32'h00001579, 0, 0, 0, "after_bp");
        run_op(32'hCAFEF00D, 5'd17, 2'b10, 5'd31,
               ref_model(32'hCAFEF00D, 17, 2'b10, 31), 1, 1, 0, "scramble");

        // Reset in the middle of a long shift must abort with no result.
        DATA_IN  = 32'hFFFF0000;
        AMOUNT   = 5'd31;
        MODE     = 2'b01;
        MASK_LEN = 5'd31;
        START    = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        check("midreset busy", 32'(BUSY), 32'd0);
        check("midreset valid", 32'(RESULT_VALID), 32'd0);
        check("midreset result", RESULT, 32'd0);
        @(negedge CLK);
        RESET_N     = 1'b1;
        never_valid = 1;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            if (RESULT_VALID || BUSY) never_valid = 0;
        end
        check("midreset quiet", 32'(never_valid), 32'd1);

        for (int n = 0; n < 150; n++) begin
            d  = $urandom;
            a  = 5'($urandom);
            md = 2'($urandom);
            ln = 5'($urandom);
            if (n % 4 == 0) d[31] = 1'b1;
            run_op(d, a, md, ln, ref_model(d, int'(a), md, int'(ln)),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
